stbuf_coalesce: RTL and testbench



---
 rtl/stbuf_coalesce.sv | 109 ++++++++++
 tb/tb_stbuf_coalesce.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stbuf_coalesce.sv
// Coalescing store buffer: in-order FIFO of word stores that merges a store into the youngest
// entry when it targets the same word. It drains over valid/ready and flags overlapping loads.
module stbuf_coalesce #(
   parameter int unsigned WORDLEN = 64,
   parameter int unsigned PA_BITS = 56,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         StoreValid,
   output logic                         StoreReady,
   input  logic [PA_BITS-1:0]           StoreAdr,
   input  logic [WORDLEN/8-1:0]         StoreByteMask,
   input  logic [WORDLEN-1:0]           StoreWriteData,
   input  logic                         Flush,
   output logic                         BusValid,
   input  logic                         BusReady,
   output logic [PA_BITS-1:0]           BusAdr,
   output logic [WORDLEN-1:0]           BusData,
   output logic [WORDLEN/8-1:0]         BusByteMask,
   input  logic [PA_BITS-1:0]           LoadAdr,
   output logic                         LoadConflict,
   output logic                         Empty,
   output logic [$clog2(DEPTH+1)-1:0]   Count
);

   localparam int unsigned OFS = $clog2(WORDLEN/8);
   localparam int unsigned NB  = WORDLEN/8;
   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH+1);
   localparam int unsigned AW  = PA_BITS - OFS;

   logic [AW-1:0]      r_adr   [DEPTH];
   logic [WORDLEN-1:0] r_data  [DEPTH];
   logic [NB-1:0]      r_mask  [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_count;

   logic [PW-1:0]      w_young;
   logic [AW-1:0]      w_store_word;
   logic               w_hit;
   logic               w_push;
   logic               w_alloc;
   logic               w_coal;
   logic               w_pop;
   logic               w_unused;

   assign w_young      = r_tail - PW'(1);
   assign w_store_word = StoreAdr[PA_BITS-1:OFS];
   // Count >= 2 keeps the head entry out of coalescing so bus outputs stay stable.
   assign w_hit        = (r_count >= CW'(2)) && (r_adr[w_young] == w_store_word);
   assign StoreReady   = !Flush && ((r_count < CW'(DEPTH)) || w_hit);
   assign w_push       = StoreValid && StoreReady && (|StoreByteMask);
   assign w_alloc      = w_push && !w_hit;
   assign w_coal       = w_push && w_hit;
   assign w_pop        = r_valid[r_head] && BusReady;
   assign w_unused     = ^{StoreAdr[OFS-1:0], LoadAdr[OFS-1:0]};

   assign BusValid    = r_valid[r_head];
   assign BusAdr      = {r_adr[r_head], {OFS{1'b0}}};
   assign BusData     = r_data[r_head];
   assign BusByteMask = r_mask[r_head];
   assign Empty       = (r_count == '0);
   assign Count       = r_count;

   always_comb begin
      LoadConflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_adr[i] == LoadAdr[PA_BITS-1:OFS])) LoadConflict = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_adr[i]  <= '0;
            r_data[i] <= '0;
            r_mask[i] <= '0;
         end
      end else begin
         // A full buffer refuses allocation, so alloc and pop never share an index.
         if (w_alloc) begin
            r_valid[r_tail] <= 1'b1;
            r_adr[r_tail]   <= w_store_word;
            r_data[r_tail]  <= StoreWriteData;
            r_mask[r_tail]  <= StoreByteMask;
            r_tail          <= r_tail + PW'(1);
         end
         if (w_coal) begin
            for (int b = 0; b < NB; b++) begin
               if (StoreByteMask[b]) r_data[w_young][b*8 +: 8] <= StoreWriteData[b*8 +: 8];
            end
            r_mask[w_young] <= r_mask[w_young] | StoreByteMask;
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_stbuf_coalesce.sv
// Self-checking bench for stbuf_coalesce: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer contents.
module tb_stbuf_coalesce;

   logic        clk = 1'b0;
   logic        reset;
   logic        StoreValid;
   logic        StoreReady;
   logic [55:0] StoreAdr;
   logic [7:0]  StoreByteMask;
   logic [63:0] StoreWriteData;
   logic        Flush;
   logic        BusValid;
   logic        BusReady;
   logic [55:0] BusAdr;
   logic [63:0] BusData;
   logic [7:0]  BusByteMask;
   logic [55:0] LoadAdr;
   logic        LoadConflict;
   logic        Empty;
   logic [2:0]  Count;

   stbuf_coalesce dut (
      .clk(clk), .reset(reset), .StoreValid(StoreValid), .StoreReady(StoreReady),
      .StoreAdr(StoreAdr), .StoreByteMask(StoreByteMask), .StoreWriteData(StoreWriteData),
      .Flush(Flush), .BusValid(BusValid), .BusReady(BusReady), .BusAdr(BusAdr),
      .BusData(BusData), .BusByteMask(BusByteMask), .LoadAdr(LoadAdr),
      .LoadConflict(LoadConflict), .Empty(Empty), .Count(Count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [55:0] adr;
      logic [63:0] data;
      logic [7:0]  mask;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [55:0] word_of(input logic [55:0] a);
      return {a[55:3], 3'b000};
   endfunction

   task automatic set_store(input logic v, input logic [55:0] a, input logic [7:0] m,
                            input logic [63:0] d);
      StoreValid = v; StoreAdr = a; StoreByteMask = m; StoreWriteData = d;
   endtask

   // Check every output against the model, clock once, then apply the model's own rules.
   task automatic step();
      bit   hit, rdy, pop, conf;
      ent_t e;
      #1;
      hit  = (q.size() >= 2) && (q[q.size()-1].adr == word_of(StoreAdr));
      rdy  = !Flush && ((q.size() < 4) || hit);
      pop  = (q.size() > 0) && BusReady;
      conf = 1'b0;
      foreach (q[i]) if (q[i].adr == word_of(LoadAdr)) conf = 1'b1;
      check("count", 64'(Count), 64'(q.size()));
      check("empty", 64'(Empty), 64'(q.size() == 0));
      check("store_ready", 64'(StoreReady), 64'(rdy));
      check("bus_valid", 64'(BusValid), 64'(q.size() > 0));
      check("load_conflict", 64'(LoadConflict), 64'(conf));
      if (q.size() > 0) begin
         check("bus_adr", 64'(BusAdr), 64'(q[0].adr));
         check("bus_data", BusData, q[0].data);
         check("bus_mask", 64'(BusByteMask), 64'(q[0].mask));
      end
      @(posedge clk);
      if (StoreValid && rdy && (StoreByteMask != 8'h00)) begin
         if (hit) begin
            e = q[q.size()-1];
            for (int b = 0; b < 8; b++)
               if (StoreByteMask[b]) e.data[b*8 +: 8] = StoreWriteData[b*8 +: 8];
            e.mask = e.mask | StoreByteMask;
            q[q.size()-1] = e;
         end else begin
            q.push_back('{adr: word_of(StoreAdr), data: StoreWriteData, mask: StoreByteMask});
         end
      end
      if (pop) void'(q.pop_front());
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_count", 64'(Count), 64'd0);
      check("rst_bus_valid", 64'(BusValid), 64'd0);
      check("rst_empty", 64'(Empty), 64'd1);
      check("rst_bus_adr", 64'(BusAdr), 64'd0);
      check("rst_bus_data", BusData, 64'd0);
      check("rst_bus_mask", 64'(BusByteMask), 64'd0);
      check("rst_conflict", 64'(LoadConflict), 64'd0);
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      set_store(1'b0, '0, '0, '0);
      Flush = 1'b0; BusReady = 1'b0; LoadAdr = 56'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset mid-stream with three buffered entries
      for (int i = 0; i < 3; i++) begin
         set_store(1'b1, 56'h500 + 56'(i*8), 8'hFF, 64'(i + 1));
         step();
      end
      check("pre_rst_count", 64'(Count), 64'd3);
      #2;
      do_reset();
      set_store(1'b1, 56'h1000, 8'h0F, 64'h11223344);
      step();
      set_store(1'b0, '0, '0, '0);
      check("first_valid", 64'(BusValid), 64'd1);
      check("first_adr", 64'(BusAdr), 64'h1000);
      check("first_mask", 64'(BusByteMask), 64'h0F);
      do_reset();

      // Coalesce into youngest, never into head
      set_store(1'b1, 56'h2000, 8'h01, 64'hAAAA_AAAA_AAAA_AAAA); step();
      set_store(1'b1, 56'h3008, 8'h03, 64'h1111_1111_1111_2222); step();
      set_store(1'b1, 56'h300C, 8'hF0, 64'h9988_7766_5555_5555); step();
      set_store(1'b0, '0, '0, '0);
      check("coal_count", 64'(Count), 64'd2);
      check("coal_head_mask", 64'(BusByteMask), 64'h01);
      BusReady = 1'b1; step(); BusReady = 1'b0;
      check("coal_adr", 64'(BusAdr), 64'h3008);
      check("coal_mask", 64'(BusByteMask), 64'hF3);
      check("coal_data", BusData, 64'h9988_7766_1111_2222);
      do_reset();

      // Full, coalesce while full, refuse push+pop at full, drain and wrap
      for (int i = 0; i < 4; i++) begin
         set_store(1'b1, 56'h6000 + 56'(i*8), 8'h0F, 64'(32'hC0DE0000 + i)); step();
      end
      set_store(1'b1, 56'h7000, 8'h01, 64'h1);
      #1;
      check("full_count", 64'(Count), 64'd4);
      check("full_refuse", 64'(StoreReady), 64'd0);
      BusReady = 1'b1; step(); BusReady = 1'b0;
      check("full_pop_refused", 64'(Count), 64'd3);
      set_store(1'b1, 56'h7000, 8'h01, 64'h1); step();
      set_store(1'b1, 56'h7000, 8'h30, 64'h0000_5500_0000_0000);
      #1;
      check("full_coal_ready", 64'(StoreReady), 64'd1);
      step();
      set_store(1'b0, '0, '0, '0);
      BusReady = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("drained", 64'(Empty), 64'd1);
      for (int i = 0; i < 3; i++) begin
         set_store(1'b1, 56'h8000 + 56'(i*8), 8'hFF, 64'(i)); step();
      end
      set_store(1'b0, '0, '0, '0);
      for (int i = 0; i < 3; i++) step();
      BusReady = 1'b0;
      do_reset();

      // Simultaneous push and pop at Count=2
      set_store(1'b1, 56'h9000, 8'hFF, 64'h1); step();
      set_store(1'b1, 56'h9008, 8'hFF, 64'h2); step();
      set_store(1'b1, 56'h9010, 8'hFF, 64'h3); BusReady = 1'b1; step();
      set_store(1'b0, '0, '0, '0); BusReady = 1'b0;
      check("simul_count", 64'(Count), 64'd2);

      // Flush blocks intake while draining; zero-mask store is a no-op
      set_store(1'b1, 56'h9018, 8'hFF, 64'h4); step();
      Flush = 1'b1; set_store(1'b1, 56'hA000, 8'hFF, 64'h5);
      #1;
      check("flush_ready", 64'(StoreReady), 64'd0);
      BusReady = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("flush_empty", 64'(Empty), 64'd1);
      Flush = 1'b0; BusReady = 1'b0;
      set_store(1'b1, 56'hB000, 8'h00, 64'hDEAD);
      #1;
      check("zero_mask_ready", 64'(StoreReady), 64'd1);
      step();
      set_store(1'b0, '0, '0, '0);
      check("zero_mask_count", 64'(Count), 64'd0);

      // LoadConflict
      set_store(1'b1, 56'h4000, 8'h01, 64'h1); step();
      set_store(1'b1, 56'h4010, 8'h01, 64'h2); step();
      set_store(1'b0, '0, '0, '0);
      LoadAdr = 56'h4013; #1; check("conf_hit", 64'(LoadConflict), 64'd1);
      LoadAdr = 56'h4008; #1; check("conf_miss", 64'(LoadConflict), 64'd0);
      LoadAdr = 56'h4013; BusReady = 1'b1; step(); step(); BusReady = 1'b0;
      check("conf_gone", 64'(LoadConflict), 64'd0);

      // Random traffic over a small address pool
      for (int n = 0; n < 1500; n++) begin
         set_store($urandom_range(0, 3) != 0,
                   56'hC000 + 56'($urandom_range(0, 3) * 8) + 56'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                   {$urandom, $urandom});
         BusReady = $urandom_range(0, 2) == 0;
         Flush    = $urandom_range(0, 15) == 0;
         LoadAdr  = 56'hC000 + 56'($urandom_range(0, 5) * 8) + 56'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
